// File: rtl/ntt_coeff_stream_ctrl.sv
// ntt_coeff_stream_ctrl: loads coefficients (mod Q) into BRAM, kicks the NTT core, streams results back out.
module ntt_coeff_stream_ctrl #(
  parameter int N          = 256,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int Q          = 3329,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  op_mode,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  ntt_enable,
  output logic                  ntt_mode,
  input  logic                  ntt_done
);
  localparam int D  = RD_LAT + 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic mode_q, done_q, fd_q;
  logic [ADDR_WIDTH-1:0] wcnt_q, ocnt_q;
  logic [ADDR_WIDTH:0] rcnt_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [DATA_WIDTH-1:0] mem_q [D];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q, inflight;
  logic [CW:0] occ;
  logic s_fire, m_fire, issue, arrive, done_rise;
  logic [DATA_WIDTH-1:0] red;
  assign red        = (s_data >= DATA_WIDTH'(Q)) ? s_data - DATA_WIDTH'(Q) : s_data;
  assign s_ready    = state_q == LOAD;
  assign s_fire     = s_ready && s_valid;
  assign m_valid    = (state_q == DRAIN) && (fcnt_q != '0);
  assign m_data     = m_valid ? mem_q[rp_q] : '0;
  assign m_last     = m_valid && (ocnt_q == ADDR_WIDTH'(N - 1));
  assign m_fire     = m_valid && m_ready;
  assign arrive     = pipe_q[RD_LAT-1];
  assign done_rise  = (state_q == WAIT) && ntt_done && !done_q;
  assign occ        = {1'b0, inflight} + {1'b0, fcnt_q};
  // A slot freed by this cycle's pop is reusable now, keeping DRAIN at one beat per cycle.
  assign issue      = (state_q == DRAIN) && (rcnt_q < (ADDR_WIDTH+1)'(N)) &&
                      (occ < (CW+1)'(D) + {{CW{1'b0}}, m_fire});
  assign bram_en    = s_fire || issue;
  assign bram_we    = s_fire;
  assign bram_addr  = s_fire ? wcnt_q : issue ? rcnt_q[ADDR_WIDTH-1:0] : '0;
  assign bram_din   = s_fire ? red : '0;
  assign ntt_enable = state_q == KICK;
  assign ntt_mode   = ((state_q == KICK) || (state_q == WAIT)) && mode_q;
  assign busy       = state_q != IDLE;
  assign frame_done = fd_q;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_q[i]);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? LOAD : IDLE;
      LOAD:    state_d = (s_fire && wcnt_q == ADDR_WIDTH'(N - 1)) ? KICK : LOAD;
      KICK:    state_d = WAIT;
      WAIT:    state_d = done_rise ? DRAIN : WAIT;
      DRAIN:   state_d = (m_fire && m_last) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      fd_q    <= 1'b0;
      wcnt_q  <= '0;
      ocnt_q  <= '0;
      rcnt_q  <= '0;
      pipe_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= ntt_done;
      fd_q    <= m_fire && m_last;
      if (state_q == IDLE && go) begin
        mode_q <= op_mode;
        wcnt_q <= '0;
      end
      if (s_fire) wcnt_q <= wcnt_q + 1'b1;
      if (state_q == WAIT) begin
        rcnt_q <= '0;
        ocnt_q <= '0;
      end
      if (issue) rcnt_q <= rcnt_q + 1'b1;
      pipe_q <= RD_LAT'({pipe_q, issue});
      if (arrive) wp_q <= (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
      if (m_fire) begin
        rp_q   <= (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
        ocnt_q <= ocnt_q + 1'b1;
      end
      fcnt_q <= fcnt_q + CW'(arrive) - CW'(m_fire);
    end
  end
  always_ff @(posedge clk) if (arrive) mem_q[wp_q] <= bram_dout;
endmodule

// File: tb/tb_ntt_coeff_stream_ctrl.sv
// tb_ntt_coeff_stream_ctrl: directed frames against BRAM and core models, with write/output scoreboards.
module tb_ntt_coeff_stream_ctrl;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0, op_mode = 1'b0, s_valid = 1'b0;
  logic force_done = 1'b0, rnd_ready = 1'b0, m_ready;
  logic [11:0] s_data = '0;
  logic busy, frame_done, s_ready, m_valid, m_last, bram_en, bram_we, ntt_enable, ntt_mode, ntt_done;
  logic core_done;
  logic [11:0] m_data, bram_din, bram_dout, rd1;
  logic [7:0] bram_addr;
  logic [11:0] mem [256];
  logic [11:0] d [256];
  logic [19:0] wq [$];
  logic [12:0] oq [$];
  int ccnt = 0, total = 0, bad = 0, en_cnt = 0, e0, stall_cyc, mode_low;
  logic prev_fire = 1'b0;

  ntt_coeff_stream_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .op_mode(op_mode), .busy(busy), .frame_done(frame_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .ntt_enable(ntt_enable), .ntt_mode(ntt_mode), .ntt_done(ntt_done)
  );

  assign ntt_done = core_done | force_done;
  always #5 clk = ~clk;

  // BRAM port B with 2-cycle read latency, plus a core that rewrites the BRAM and pulses done
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    rd1       <= (bram_en && !bram_we) ? mem[bram_addr] : 12'hFFF;
    bram_dout <= rd1;
    ccnt      <= ntt_enable ? 100 : (ccnt > 0 ? ccnt - 1 : 0);
    core_done <= (ccnt == 1);
    if (ccnt == 1) for (int a = 0; a < 256; a++) mem[a] <= 12'(a) ^ 12'h5A5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] w;
    logic [12:0] o;
    check("frame_done_timing", 32'(frame_done), 32'(prev_fire));
    prev_fire = m_valid && m_ready && m_last;
    en_cnt += int'(ntt_enable);
    if (m_valid && m_ready) begin
      check("out_expected", 32'(oq.size() > 0), 1);
      if (oq.size() > 0) begin
        o = oq.pop_front();
        check("m_data", 32'(m_data), 32'(o[11:0]));
        check("m_last", 32'(m_last), 32'(o[12]));
      end
    end
    if (bram_en && bram_we) begin
      check("write_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("wr_addr", 32'(bram_addr), 32'(w[19:12]));
        check("wr_din", 32'(bram_din), 32'(w[11:0]));
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ctl"}, 32'({busy, frame_done, s_ready, m_valid, m_last, bram_en, bram_we, ntt_enable, ntt_mode}), 0);
    check({tag, "_bus"}, {bram_addr, bram_din, m_data}, 0);
  endtask

  task automatic put(input logic [11:0] x);
    int n = 0;
    s_valid = 1'b1;
    s_data  = x;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic frame(input logic mode, input bit gaps, input int go_at);
    for (int a = 0; a < 256; a++) begin
      wq.push_back({8'(a), (d[a] >= 12'd3329) ? d[a] - 12'd3329 : d[a]});
      oq.push_back({a == 255, 12'(a) ^ 12'h5A5});
    end
    go = 1'b1; op_mode = mode;
    step();
    go = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
      if (i == go_at) begin go = 1'b1; op_mode = !mode; end
      put(d[i]);
      go = 1'b0; op_mode = mode;
    end
    @(negedge clk);
    check("kick_enable", 32'(ntt_enable), 1);
    check("kick_mode", 32'(ntt_mode), 32'(mode));
    check("kick_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    check("wait_enable", 32'(ntt_enable), 0);
    check("wait_mode", 32'(ntt_mode), 32'(mode));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 5000) begin @(negedge clk); n++; end
    check("frame_done_seen", 32'(frame_done), 1);
    check("out_left", oq.size(), 0);
    check("wr_left", wq.size(), 0);
  endtask

  initial begin
    go = 1'b1; s_valid = 1'b1; s_data = 12'hABC;
    repeat (3) step();
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0; go = 1'b0; s_valid = 1'b0;
    step();
    // T1/T2: all-ones load, back-to-back, then full-rate drain
    for (int a = 0; a < 256; a++) d[a] = 12'd1;
    e0 = en_cnt;
    frame(1'b0, 1'b0, -1);
    wait_done();
    check("t1_enable_pulses", en_cnt - e0, 1);
    // T3: reduction boundaries
    for (int a = 0; a < 256; a++) d[a] = 12'($urandom_range(0, 4095));
    d[0] = 12'd3328; d[1] = 12'd3329; d[2] = 12'd4095; d[3] = 12'd0;
    step();
    frame(1'b0, 1'b0, -1);
    wait_done();
    // T4: input gaps and random output backpressure
    for (int a = 0; a < 256; a++) d[a] = 12'($urandom_range(0, 4095));
    rnd_ready = 1'b1;
    step();
    frame(1'b0, 1'b1, -1);
    wait_done();
    rnd_ready = 1'b0;
    // T5: stale high done must not start the drain
    force_done = 1'b1;
    step();
    frame(1'b1, 1'b0, -1);
    stall_cyc = 0; mode_low = 0;
    repeat (150) begin
      @(negedge clk);
      stall_cyc += int'(bram_en || m_valid);
      mode_low  += int'(!ntt_mode);
    end
    check("t5_no_early_drain", stall_cyc, 0);
    check("t5_mode_held", mode_low, 0);
    check("t5_busy", 32'(busy), 1);
    step(); force_done = 1'b0;
    step(); force_done = 1'b1;
    step(); force_done = 1'b0;
    @(negedge clk);
    wait_done();
    // T6: reset in WAIT aborts; a go during the next LOAD is ignored
    step();
    frame(1'b0, 1'b0, -1);
    repeat (20) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_idle("abort");
    check("abort_wr_left", wq.size(), 0);
    oq.delete();
    rst = 1'b0;
    step();
    frame(1'b0, 1'b0, 100);
    wait_done();
    repeat (5) step();
    @(negedge clk);
    check("t6_idle_after", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
